spi_block_sequencer: RTL and testbench
======================================

# spi_block_sequencer

Avalon-MM controlled sequencer for the SpeedSPI datapath. It issues a one-byte command, waits for a 0xFE data-start token, and streams LEN data bytes to the downstream buffer. It then receives and checks a 16-bit CRC, and exposes the error flag and CRC at the same register addresses (6, 7) the SpeedSPI output block uses. It sits between the Nios-side Avalon bus and the SPI pins and owns chip-select and clocking.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period (≥2).
- MAX_LEN, 512: maximum data bytes per block.
- TOKEN_TIMEOUT, 255: max 0xFF-filler bytes while waiting for the token.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- avs_s0_write  in  1  register write strobe.
- avs_s0_read  in  1  register read strobe.
- avs_s0_address  in  12  word address.
- avs_s0_writedata  in  32  write data.
- avs_s0_readdata  out  32  registered read data; 0 when not reading.
- spi_sclk  out  1  SPI clock, mode 0.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in.
- spi_cs_n  out  1  chip select, active-low.
- byte_data  out  8  received data byte.
- byte_valid  out  1  one-cycle strobe qualifying byte_data.
- irq  out  1  level, high while done is set.

## Operation
- Registers:
  - 0 CTRL (W): bit0 start, bit1 abort.
  - 1 LEN (R/W): writes of 0 are stored as 0; writes above MAX_LEN are stored as MAX_LEN.
  - 2 CMD (R/W): bits[7:0].
  - 3 STATUS (R): bit0 busy, bit1 done, bit2 error. Reading clears done.
  - 6 (R): error, zero-extended.
  - 7 (R): crc_out = {16'b0, computed CRC}.
  - Any other address reads 0.
- FSM IDLE → CMD → TOKEN → DATA → CRC → DONE → IDLE.
  - IDLE: on start, clear error/done/CRC, assert cs_n low, go to CMD. If LEN=0, go straight to DONE with error=1 instead.
  - CMD: shift CMD out MSB first, discard the received byte.
  - TOKEN: shift 0xFF. Received 0xFE → DATA. Any other byte increments the counter. Counter reaching TOKEN_TIMEOUT → DONE with error=1.
  - DATA: shift 0xFF. Each received byte drives byte_data and pulses byte_valid, and updates the CRC. After LEN bytes → CRC.
  - CRC: receive 2 bytes MSB first. Mismatch with the computed CRC sets error=1.
  - DONE: cs_n high for one SCLK half-period, then set done and go to IDLE.
- CRC is CRC-16-CCITT: poly 0x1021, init 0x0000, no reflection, no final XOR. It covers data bytes only.
- Abort, in any busy state: same cycle, cs_n=1, sclk=0, mosi=1, error=1, done=1, state IDLE; no further byte_valid.
- Start while busy is ignored. Start and abort in the same write: abort wins; start is ignored.

## Timing
- Reset values:
  - spi_sclk 0, spi_mosi 1, spi_cs_n 1
  - byte_data 0, byte_valid 0, irq 0, avs_s0_readdata 0
  - FSM IDLE; CRC, error, done, LEN, CMD all 0
- Read latency is 1 clk: readdata is valid the cycle after avs_s0_read. It returns 0 in any cycle without a read.
- SPI mode 0:
  - MOSI changes on falling SCLK, or on cs_n assertion for the first bit.
  - MISO is sampled on rising SCLK.
  - One bit = 2·CLK_DIV clk; one byte = 16·CLK_DIV clk.
- First SCLK rising edge occurs CLK_DIV clk after cs_n falls.
- byte_valid pulses the clk after the 8th rising-edge sample of each data byte.
- irq and STATUS.done rise together.
- A STATUS read coinciding with done being set leaves done=1 (set wins).
- Async reset mid-transfer forces all reset values immediately, including cs_n=1.

## Structure
- Shared package spi_seq_pkg:
  - state enum
  - register address constants (ADDR_CTRL=0, LEN=1, CMD=2, STATUS=3, ERROR=6, CRC=7)
  - TOKEN_START=8'hFE, FILL_BYTE=8'hFF, CRC_POLY=16'h1021
- Sub-module spi_byte_shifter: 8-bit mode-0 shifter with CLK_DIV divider.
  - Inputs: load, tx_byte.
  - Outputs: rx_byte, byte_done pulse, sclk, mosi.
- Sequencer FSM, CRC and register file live in the top module.

## Test plan
- CLK_DIV=2, CMD=0x51, LEN=4. Slave returns 0xFF ×3, 0xFE, data 01 02 03 04, CRC 0x0D03 (computed reference) → 4 byte_valid pulses with 01..04, STATUS=0b010, reg7=0x00000D03, irq=1.
- Same as the first case but the slave CRC is 0x0000 → error=1, reg6=1, data still streamed.
- Slave always returns 0xFF, TOKEN_TIMEOUT=3 → DONE after CMD plus 3 filler bytes, error=1, no byte_valid.
- Abort written mid-DATA → cs_n=1 next cycle, STATUS=0b110. A subsequent start with LEN=1 completes normally.
- LEN written 0 then start → done=1, error=1, cs_n never asserted. LEN written 1000 → reads back 512.
- rst asserted mid-CMD → all outputs at reset values within the same cycle. A read at address 5 returns 0.

Source files
------------

// File: rtl/spi_block_sequencer_pkg.sv
// Shared types, register map and CRC helper for the SPI block sequencer.
package spi_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_TOKEN,
      ST_DATA,
      ST_CRC,
      ST_DONE
   } seq_state_t;

   localparam logic [11:0] ADDR_CTRL   = 12'd0;
   localparam logic [11:0] ADDR_LEN    = 12'd1;
   localparam logic [11:0] ADDR_CMD    = 12'd2;
   localparam logic [11:0] ADDR_STATUS = 12'd3;
   localparam logic [11:0] ADDR_ERROR  = 12'd6;
   localparam logic [11:0] ADDR_CRC    = 12'd7;

   localparam logic [7:0]  TOKEN_START = 8'hFE;
   localparam logic [7:0]  FILL_BYTE   = 8'hFF;
   localparam logic [15:0] CRC_POLY    = 16'h1021;

   // CRC-16-CCITT, MSB first, one byte at a time
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = (c << 1) ^ CRC_POLY;
         else                 c = c << 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/spi_block_sequencer_if.sv
// Avalon-MM slave port of the sequencer register file.
interface spi_block_sequencer_if;
   logic        avs_s0_write;
   logic        avs_s0_read;
   logic [11:0] avs_s0_address;
   logic [31:0] avs_s0_writedata;
   logic [31:0] avs_s0_readdata;

   modport master (output avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_writedata,
                   input  avs_s0_readdata);
   modport slave  (input  avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_writedata,
                   output avs_s0_readdata);
endinterface

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte shifter; a load during a byte queues the next byte so bytes run back to back.
module spi_byte_shifter #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic [7:0] rx_byte,
   output logic       byte_done,
   output logic       sclk,
   output logic       mosi,
   output logic       busy
);
   localparam logic [7:0] HALF = 8'(CLK_DIV - 1);

   logic       active_q, sclk_q, mosi_q, done_q, nxt_pend_q;
   logic [7:0] div_q, tx_q, rx_q, nxt_q;
   logic [2:0] bit_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0; sclk_q <= 1'b0; mosi_q <= 1'b1; done_q <= 1'b0;
         nxt_pend_q <= 1'b0; div_q <= '0; tx_q <= '0; rx_q <= '0; nxt_q <= '0; bit_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (clear) begin
            active_q <= 1'b0; sclk_q <= 1'b0; mosi_q <= 1'b1; nxt_pend_q <= 1'b0;
         end else if (!active_q) begin
            if (load) begin
               active_q <= 1'b1; tx_q <= tx_byte; mosi_q <= tx_byte[7];
               div_q <= HALF; bit_q <= '0; sclk_q <= 1'b0;
            end
         end else begin
            if (load) begin
               nxt_pend_q <= 1'b1; nxt_q <= tx_byte;
            end
            if (div_q != '0) begin
               div_q <= div_q - 8'd1;
            end else begin
               div_q <= HALF;
               if (!sclk_q) begin
                  sclk_q <= 1'b1;
                  rx_q   <= {rx_q[6:0], miso};
                  if (bit_q == 3'd7) done_q <= 1'b1;
               end else begin
                  sclk_q <= 1'b0;
                  if (bit_q == 3'd7) begin
                     bit_q <= '0;
                     // the follow-on load always lands at least one cycle before this falling edge
                     if (nxt_pend_q) begin
                        tx_q <= nxt_q; mosi_q <= nxt_q[7]; nxt_pend_q <= 1'b0;
                     end else begin
                        active_q <= 1'b0; mosi_q <= 1'b1;
                     end
                  end else begin
                     bit_q  <= bit_q + 3'd1;
                     tx_q   <= tx_q << 1;
                     mosi_q <= tx_q[6];
                  end
               end
            end
         end
      end
   end

   assign rx_byte   = rx_q;
   assign byte_done = done_q;
   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign busy      = active_q;
endmodule

// File: rtl/spi_block_sequencer.sv
// Command / token / data / CRC block-read sequencer with Avalon-MM register file.
//   state    | meaning
//   ST_IDLE  | cs_n high, waiting for start
//   ST_CMD   | shifting the command byte, response discarded
//   ST_TOKEN | shifting 0xFF until 0xFE or timeout
//   ST_DATA  | streaming LEN data bytes, CRC accumulated
//   ST_CRC   | receiving the two CRC bytes
//   ST_DONE  | finish last byte, cs_n high one half-period, then set done
module spi_block_sequencer
   import spi_seq_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int MAX_LEN       = 512,
   parameter int TOKEN_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_block_sequencer_if.slave  avs,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   input  logic                  spi_miso,
   output logic                  spi_cs_n,
   output logic [7:0]            byte_data,
   output logic                  byte_valid,
   output logic                  irq
);
   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
   localparam logic [15:0] TIMEOUT_W = 16'(TOKEN_TIMEOUT);
   localparam logic [7:0]  HALF      = 8'(CLK_DIV - 1);

   seq_state_t  state_q, state_nxt;
   logic        cs_n_q, err_q, done_q, byte_valid_q;
   logic [15:0] crc_q, crc_rx_q, len_q, cnt_q;
   logic [7:0]  cmd_q, hp_q, byte_data_q;
   logic [31:0] readdata_q;
   logic        sh_load, sh_done, sh_busy;
   logic [7:0]  sh_tx, sh_rx;

   logic wr_ctrl, start, abort, busy, last_data;
   assign wr_ctrl   = avs.avs_s0_write && (avs.avs_s0_address == ADDR_CTRL);
   assign abort     = wr_ctrl && avs.avs_s0_writedata[1];
   assign start     = wr_ctrl && avs.avs_s0_writedata[0] && !avs.avs_s0_writedata[1];
   assign busy      = (state_q != ST_IDLE);
   assign last_data = ((cnt_q + 16'd1) == len_q);

   spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
      .clk(clk), .rst(rst), .clear(abort && busy), .load(sh_load), .tx_byte(sh_tx),
      .miso(spi_miso), .rx_byte(sh_rx), .byte_done(sh_done), .sclk(spi_sclk),
      .mosi(spi_mosi), .busy(sh_busy)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      sh_load   = 1'b0;
      sh_tx     = FILL_BYTE;
      if (abort && busy) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               if (len_q == '0) state_nxt = ST_DONE;
               else begin
                  state_nxt = ST_CMD; sh_load = 1'b1; sh_tx = cmd_q;
               end
            end
            ST_CMD: if (sh_done) begin
               state_nxt = ST_TOKEN; sh_load = 1'b1;
            end
            ST_TOKEN: if (sh_done) begin
               if (sh_rx == TOKEN_START) begin
                  state_nxt = ST_DATA; sh_load = 1'b1;
               end else if ((cnt_q + 16'd1) >= TIMEOUT_W) state_nxt = ST_DONE;
               else sh_load = 1'b1;
            end
            ST_DATA: if (sh_done) begin
               sh_load = 1'b1;
               if (last_data) state_nxt = ST_CRC;
            end
            ST_CRC: if (sh_done) begin
               if (cnt_q == 16'd1) state_nxt = ST_DONE;
               else sh_load = 1'b1;
            end
            ST_DONE: if (!sh_busy && cs_n_q && hp_q == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_n_q <= 1'b1; err_q <= 1'b0; done_q <= 1'b0; byte_valid_q <= 1'b0;
         crc_q <= '0; crc_rx_q <= '0; len_q <= '0; cnt_q <= '0;
         cmd_q <= '0; hp_q <= '0; byte_data_q <= '0; readdata_q <= '0;
      end else begin
         byte_valid_q <= 1'b0;
         readdata_q   <= '0;
         if (avs.avs_s0_read) begin
            case (avs.avs_s0_address)
               ADDR_LEN:    readdata_q <= {16'b0, len_q};
               ADDR_CMD:    readdata_q <= {24'b0, cmd_q};
               ADDR_STATUS: readdata_q <= {29'b0, err_q, done_q, busy};
               ADDR_ERROR:  readdata_q <= {31'b0, err_q};
               ADDR_CRC:    readdata_q <= {16'b0, crc_q};
               default:     readdata_q <= '0;
            endcase
            if (avs.avs_s0_address == ADDR_STATUS) done_q <= 1'b0;
         end
         if (avs.avs_s0_write) begin
            if (avs.avs_s0_address == ADDR_LEN)
               len_q <= (avs.avs_s0_writedata > 32'(MAX_LEN)) ? MAX_LEN_W : avs.avs_s0_writedata[15:0];
            if (avs.avs_s0_address == ADDR_CMD)
               cmd_q <= avs.avs_s0_writedata[7:0];
         end
         if (state_nxt == ST_DONE && state_q != ST_DONE) hp_q <= HALF;
         // later assignments to done_q win over the STATUS read clear above
         if (abort && busy) begin
            cs_n_q <= 1'b1; err_q <= 1'b1; done_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: if (start) begin
                  err_q <= (len_q == '0); done_q <= 1'b0; crc_q <= '0; cnt_q <= '0;
                  if (len_q != '0) cs_n_q <= 1'b0;
               end
               ST_CMD: if (sh_done) cnt_q <= '0;
               ST_TOKEN: if (sh_done) begin
                  if (sh_rx == TOKEN_START) cnt_q <= '0;
                  else begin
                     cnt_q <= cnt_q + 16'd1;
                     if ((cnt_q + 16'd1) >= TIMEOUT_W) err_q <= 1'b1;
                  end
               end
               ST_DATA: if (sh_done) begin
                  byte_data_q  <= sh_rx;
                  byte_valid_q <= 1'b1;
                  crc_q        <= crc16_byte(crc_q, sh_rx);
                  cnt_q        <= last_data ? 16'd0 : cnt_q + 16'd1;
               end
               ST_CRC: if (sh_done) begin
                  crc_rx_q <= {crc_rx_q[7:0], sh_rx};
                  cnt_q    <= cnt_q + 16'd1;
                  if (cnt_q == 16'd1 && {crc_rx_q[7:0], sh_rx} != crc_q) err_q <= 1'b1;
               end
               ST_DONE: if (!sh_busy) begin
                  if (!cs_n_q) begin
                     cs_n_q <= 1'b1; hp_q <= HALF;
                  end else if (hp_q != '0) hp_q <= hp_q - 8'd1;
                  else done_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign spi_cs_n            = cs_n_q;
   assign byte_data           = byte_data_q;
   assign byte_valid          = byte_valid_q;
   assign irq                 = done_q;
   assign avs.avs_s0_readdata = readdata_q;
endmodule

// File: tb/tb_spi_block_sequencer.sv
// Directed bench: SPI slave model on the main instance, a second instance with an idle-high MISO for token timeout.
module tb_spi_block_sequencer;
   import spi_seq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spi_block_sequencer_if bus();
   spi_block_sequencer_if bus_to();

   logic       sclk, mosi, cs_n, bvalid, irq;
   logic       miso = 1'b1;
   logic [7:0] bdata;
   logic       sclk_to, mosi_to, cs_n_to, bvalid_to, irq_to;
   logic       miso_to = 1'b1;
   logic [7:0] bdata_to;

   spi_block_sequencer #(.CLK_DIV(2), .MAX_LEN(512), .TOKEN_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .avs(bus.slave), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(miso), .spi_cs_n(cs_n), .byte_data(bdata), .byte_valid(bvalid), .irq(irq)
   );

   spi_block_sequencer #(.CLK_DIV(2), .MAX_LEN(512), .TOKEN_TIMEOUT(3)) dut_to (
      .clk(clk), .rst(rst), .avs(bus_to.slave), .spi_sclk(sclk_to), .spi_mosi(mosi_to),
      .spi_miso(miso_to), .spi_cs_n(cs_n_to), .byte_data(bdata_to), .byte_valid(bvalid_to), .irq(irq_to)
   );

   int vectors = 0;
   int errors  = 0;

   // mode-0 slave: first bit on cs_n fall, next bits on falling sclk
   logic [7:0] sl_q[$];
   logic [7:0] sl_sh;
   int         sl_bit;
   bit         sl_active = 1'b0;
   always @(negedge cs_n or posedge cs_n or negedge sclk) begin
      if (cs_n) sl_active = 1'b0;
      else if (!sl_active) begin
         sl_active = 1'b1;
         sl_sh = (sl_q.size() != 0) ? sl_q.pop_front() : 8'hFF;
         sl_bit = 0;
         miso = sl_sh[7];
      end else begin
         sl_bit++;
         if (sl_bit == 8) begin
            sl_sh = (sl_q.size() != 0) ? sl_q.pop_front() : 8'hFF;
            sl_bit = 0;
         end else sl_sh = sl_sh << 1;
         miso = sl_sh[7];
      end
   end

   logic [7:0] rx_log[$];
   int bv_to_cnt = 0;
   int sclk_to_rises = 0;
   always @(negedge clk) if (bvalid === 1'b1) rx_log.push_back(bdata);
   always @(negedge clk) if (bvalid_to === 1'b1) bv_to_cnt++;
   always @(posedge sclk_to) sclk_to_rises++;

   logic [7:0] cmd_seen = 8'h00;
   int mosi_n = 8;
   int cs_falls = 0;
   always @(negedge cs_n or posedge sclk) begin
      if (sclk) begin
         if (mosi_n < 8) begin
            cmd_seen = {cmd_seen[6:0], mosi};
            mosi_n++;
         end
      end else begin
         mosi_n = 0;
         cs_falls++;
      end
   end

   task automatic bus_write(input bit to, input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      if (to) begin
         bus_to.avs_s0_write = 1'b1; bus_to.avs_s0_address = a; bus_to.avs_s0_writedata = d;
      end else begin
         bus.avs_s0_write = 1'b1; bus.avs_s0_address = a; bus.avs_s0_writedata = d;
      end
      @(negedge clk);
      bus.avs_s0_write = 1'b0;
      bus_to.avs_s0_write = 1'b0;
   endtask

   task automatic bus_read(input bit to, input logic [11:0] a, output logic [31:0] d);
      @(negedge clk);
      if (to) begin
         bus_to.avs_s0_read = 1'b1; bus_to.avs_s0_address = a;
      end else begin
         bus.avs_s0_read = 1'b1; bus.avs_s0_address = a;
      end
      @(negedge clk);
      bus.avs_s0_read = 1'b0;
      bus_to.avs_s0_read = 1'b0;
      d = to ? bus_to.avs_s0_readdata : bus.avs_s0_readdata;
   endtask

   task automatic wait_irq(input bit to, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((to ? irq_to : irq) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      repeat (3) @(negedge clk);
      vectors++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
      vectors++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
      vectors++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b want 1", mosi); end
      vectors++; if ({irq, bvalid, bdata} !== 10'h0) begin errors++; $display("FAIL reset_outs: got irq=%b bv=%b bd=%h want 0", irq, bvalid, bdata); end
      vectors++; if (bus.avs_s0_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.avs_s0_readdata); end
      rst = 1'b1;
      bus_read(0, ADDR_STATUS, rd);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", rd); end
   endtask

   task automatic run_block(input logic [7:0] crc_hi, input logic [7:0] crc_lo, input logic [31:0] exp_status,
                            input logic [31:0] exp_err, input string tag);
      logic [31:0] rd;
      bit ok;
      int base;
      sl_q.delete();
      sl_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, crc_hi, crc_lo};
      base = rx_log.size();
      bus_write(0, ADDR_LEN, 32'd4);
      bus_write(0, ADDR_CMD, 32'h51);
      bus_write(0, ADDR_CTRL, 32'h1);
      wait_irq(0, 2000, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL %s_irq: got irq=%b want 1", tag, irq); end
      vectors++; if (rx_log.size() - base != 4) begin errors++; $display("FAIL %s_count: got %0d want 4", tag, rx_log.size() - base); end
      for (int i = 0; i < 4 && base + i < rx_log.size(); i++) begin
         vectors++;
         if (rx_log[base + i] !== 8'(i + 1)) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, rx_log[base + i], 8'(i + 1)); end
      end
      vectors++; if (cmd_seen !== 8'h51) begin errors++; $display("FAIL %s_cmd: got %h want 51", tag, cmd_seen); end
      vectors++; if (cs_n !== 1'b1) begin errors++; $display("FAIL %s_cs_n: got %b want 1", tag, cs_n); end
      bus_read(0, ADDR_STATUS, rd);
      vectors++; if (rd !== exp_status) begin errors++; $display("FAIL %s_status: got %h want %h", tag, rd, exp_status); end
      vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL %s_irq_clear: got %b want 0", tag, irq); end
      bus_read(0, ADDR_CRC, rd);
      vectors++; if (rd !== 32'h0000_0D03) begin errors++; $display("FAIL %s_crc: got %h want 00000d03", tag, rd); end
      bus_read(0, ADDR_ERROR, rd);
      vectors++; if (rd !== exp_err) begin errors++; $display("FAIL %s_err: got %h want %h", tag, rd, exp_err); end
   endtask

   task automatic test_normal();
      run_block(8'h0D, 8'h03, 32'h2, 32'h0, "normal");
   endtask

   task automatic test_crc_error();
      run_block(8'h00, 8'h00, 32'h6, 32'h1, "crc_err");
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      bit ok;
      int bv0, r0;
      bv0 = bv_to_cnt;
      r0  = sclk_to_rises;
      bus_write(1, ADDR_LEN, 32'd4);
      bus_write(1, ADDR_CTRL, 32'h1);
      wait_irq(1, 2000, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL timeout_irq: got irq=%b want 1", irq_to); end
      vectors++; if (sclk_to_rises - r0 != 32) begin errors++; $display("FAIL timeout_sclks: got %0d want 32", sclk_to_rises - r0); end
      vectors++; if (bv_to_cnt != bv0) begin errors++; $display("FAIL timeout_bvalid: got %0d want 0", bv_to_cnt - bv0); end
      bus_read(1, ADDR_ERROR, rd);
      vectors++; if (rd !== 32'h1) begin errors++; $display("FAIL timeout_err: got %h want 1", rd); end
      bus_read(1, ADDR_STATUS, rd);
      vectors++; if (rd !== 32'h6) begin errors++; $display("FAIL timeout_status: got %h want 6", rd); end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      bit ok;
      int base, n;
      sl_q.delete();
      sl_q = '{8'hFF, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h44};
      base = rx_log.size();
      bus_write(0, ADDR_LEN, 32'd4);
      bus_write(0, ADDR_CTRL, 32'h1);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (rx_log.size() > base) begin ok = 1'b1; break; end
      end
      vectors++; if (!ok) begin errors++; $display("FAIL abort_first_byte: got %0d bytes want 1", rx_log.size() - base); end
      bus_write(0, ADDR_CTRL, 32'h2);
      vectors++; if ({cs_n, sclk, mosi} !== 3'b101) begin errors++; $display("FAIL abort_pins: got cs=%b sclk=%b mosi=%b want 1 0 1", cs_n, sclk, mosi); end
      n = rx_log.size();
      repeat (200) @(negedge clk);
      vectors++; if (rx_log.size() != n) begin errors++; $display("FAIL abort_no_bvalid: got %0d extra want 0", rx_log.size() - n); end
      vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL abort_irq: got %b want 1", irq); end
      bus_read(0, ADDR_STATUS, rd);
      vectors++; if (rd !== 32'h6) begin errors++; $display("FAIL abort_status: got %h want 6", rd); end
      sl_q.delete();
      sl_q = '{8'hFF, 8'hFE, 8'h5A, 8'hFB, 8'hBF};
      base = rx_log.size();
      bus_write(0, ADDR_LEN, 32'd1);
      bus_write(0, ADDR_CTRL, 32'h1);
      wait_irq(0, 2000, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL after_abort_irq: got %b want 1", irq); end
      vectors++; if (rx_log.size() - base != 1 || rx_log[rx_log.size() - 1] !== 8'h5A) begin
         errors++; $display("FAIL after_abort_byte: got n=%0d last=%h want 1 5a", rx_log.size() - base, rx_log[rx_log.size() - 1]);
      end
      bus_read(0, ADDR_STATUS, rd);
      vectors++; if (rd !== 32'h2) begin errors++; $display("FAIL after_abort_status: got %h want 2", rd); end
      bus_read(0, ADDR_CRC, rd);
      vectors++; if (rd !== 32'h0000_FBBF) begin errors++; $display("FAIL after_abort_crc: got %h want 0000fbbf", rd); end
   endtask

   task automatic test_len_limits();
      logic [31:0] rd;
      bit ok;
      int f0;
      f0 = cs_falls;
      bus_write(0, ADDR_LEN, 32'd0);
      bus_read(0, ADDR_LEN, rd);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL len0_readback: got %h want 0", rd); end
      bus_write(0, ADDR_CTRL, 32'h1);
      wait_irq(0, 200, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL len0_irq: got %b want 1", irq); end
      vectors++; if (cs_falls != f0) begin errors++; $display("FAIL len0_cs: got %0d falls want 0", cs_falls - f0); end
      bus_read(0, ADDR_STATUS, rd);
      vectors++; if (rd !== 32'h6) begin errors++; $display("FAIL len0_status: got %h want 6", rd); end
      bus_write(0, ADDR_LEN, 32'd1000);
      bus_read(0, ADDR_LEN, rd);
      vectors++; if (rd !== 32'd512) begin errors++; $display("FAIL len_clamp: got %0d want 512", rd); end
      bus_write(0, ADDR_LEN, 32'd300);
      bus_read(0, ADDR_LEN, rd);
      vectors++; if (rd !== 32'd300) begin errors++; $display("FAIL len_300: got %0d want 300", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      sl_q.delete();
      bus_write(0, ADDR_LEN, 32'd4);
      bus_write(0, ADDR_CMD, 32'h51);
      bus_write(0, ADDR_CTRL, 32'h1);
      repeat (10) @(negedge clk);
      vectors++; if (cs_n !== 1'b0) begin errors++; $display("FAIL midrst_pre_cs: got %b want 0", cs_n); end
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      vectors++; if ({cs_n, sclk, mosi} !== 3'b101) begin errors++; $display("FAIL midrst_pins: got cs=%b sclk=%b mosi=%b want 1 0 1", cs_n, sclk, mosi); end
      vectors++; if ({irq, bvalid, bdata} !== 10'h0) begin errors++; $display("FAIL midrst_outs: got irq=%b bv=%b bd=%h want 0", irq, bvalid, bdata); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bus_read(0, 12'd5, rd);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL addr5: got %h want 0", rd); end
      bus_read(0, ADDR_LEN, rd);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_len: got %h want 0", rd); end
      bus_read(0, ADDR_CMD, rd);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_cmd: got %h want 0", rd); end
      bus_read(0, ADDR_STATUS, rd);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL midrst_status: got %h want 0", rd); end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.avs_s0_write = 1'b0; bus.avs_s0_read = 1'b0; bus.avs_s0_address = '0; bus.avs_s0_writedata = '0;
      bus_to.avs_s0_write = 1'b0; bus_to.avs_s0_read = 1'b0; bus_to.avs_s0_address = '0; bus_to.avs_s0_writedata = '0;
      test_reset();
      test_normal();
      test_crc_error();
      test_timeout();
      test_abort();
      test_len_limits();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
